// File: rtl/rf_arb_pkg.sv
// rf_arb_pkg: shared widths and enums for the register-file write-port arbiter
package rf_arb_pkg;
    localparam int DATA_WIDTH     = 32;
    localparam int REG_ADDR_WIDTH = 5;
    typedef enum logic {WB_PRIO, LL_PRIO} rf_arb_state_e;
    typedef enum logic [1:0] {GNT_NONE, GNT_WB, GNT_LL} rf_arb_gnt_e;
endpackage

// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: shares the register-file write port between WB (priority) and LL, with starvation guard
//   clk, rst_n                      clock, async active-low reset
//   wb_valid_i/wb_ready_o/addr/data writeback-stage request, ready is combinational
//   ll_valid_i/ll_ready_o/addr/data long-latency return request, ready is combinational
//   rd_write_en_o/rd_addr_o/rd_data_o registered register-file write port
//   ll_forced_o                     high while LL holds forced priority
module regfile_wr_arbiter
    import rf_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wb_valid_i,
    output logic                      wb_ready_o,
    input  logic [REG_ADDR_WIDTH-1:0] wb_addr_i,
    input  logic [DATA_WIDTH-1:0]     wb_data_i,
    input  logic                      ll_valid_i,
    output logic                      ll_ready_o,
    input  logic [REG_ADDR_WIDTH-1:0] ll_addr_i,
    input  logic [DATA_WIDTH-1:0]     ll_data_i,
    output logic                      rd_write_en_o,
    output logic [REG_ADDR_WIDTH-1:0] rd_addr_o,
    output logic [DATA_WIDTH-1:0]     rd_data_o,
    output logic                      ll_forced_o
);
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    rf_arb_state_e             state, state_nxt;
    rf_arb_gnt_e               gnt;
    logic [CNT_W-1:0]          starve_cnt, starve_cnt_nxt;
    logic                      denied, starve_hit;
    logic [REG_ADDR_WIDTH-1:0] win_addr;
    logic [DATA_WIDTH-1:0]     win_data;

    always_comb begin
        gnt = !rst_n ? GNT_NONE :
              (state == WB_PRIO && wb_valid_i) ? GNT_WB :
              (ll_valid_i && (state == LL_PRIO || !wb_valid_i)) ? GNT_LL : GNT_NONE;
        // Only denials in WB_PRIO count; LL_PRIO always resets the counter.
        denied         = state == WB_PRIO && ll_valid_i && gnt != GNT_LL;
        starve_hit     = denied && starve_cnt == CNT_W'(STARVE_LIMIT - 1);
        state_nxt      = starve_hit ? LL_PRIO : WB_PRIO;
        starve_cnt_nxt = (denied && !starve_hit) ? starve_cnt + 1'b1 : '0;
        win_addr       = gnt == GNT_LL ? ll_addr_i : wb_addr_i;
        win_data       = gnt == GNT_LL ? ll_data_i : wb_data_i;
    end

    assign wb_ready_o  = gnt == GNT_WB;
    assign ll_ready_o  = gnt == GNT_LL;
    assign ll_forced_o = state == LL_PRIO;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= WB_PRIO;
            starve_cnt    <= '0;
            rd_write_en_o <= 1'b0;
            rd_addr_o     <= '0;
            rd_data_o     <= '0;
        end else begin
            state         <= state_nxt;
            starve_cnt    <= starve_cnt_nxt;
            // x0 writes are accepted but never reach the register file.
            rd_write_en_o <= gnt != GNT_NONE && win_addr != '0;
            if (gnt != GNT_NONE) begin
                rd_addr_o <= win_addr;
                rd_data_o <= win_data;
            end
        end
    end
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb_regfile_wr_arbiter: directed and random checks of the write-port arbiter against a behavioural model
module tb_regfile_wr_arbiter;
    import rf_arb_pkg::*;
    localparam int LIM = 4;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic                      wb_valid_i = 1'b0, ll_valid_i = 1'b0;
    logic [REG_ADDR_WIDTH-1:0] wb_addr_i = '0, ll_addr_i = '0;
    logic [DATA_WIDTH-1:0]     wb_data_i = '0, ll_data_i = '0;
    logic                      wb_ready_o, ll_ready_o, rd_write_en_o, ll_forced_o;
    logic [REG_ADDR_WIDTH-1:0] rd_addr_o;
    logic [DATA_WIDTH-1:0]     rd_data_o;

    always #5 clk = ~clk;

    regfile_wr_arbiter #(.STARVE_LIMIT(LIM)) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_valid_i(wb_valid_i), .wb_ready_o(wb_ready_o), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
        .ll_valid_i(ll_valid_i), .ll_ready_o(ll_ready_o), .ll_addr_i(ll_addr_i), .ll_data_i(ll_data_i),
        .rd_write_en_o(rd_write_en_o), .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o),
        .ll_forced_o(ll_forced_o)
    );

    int passes = 0, total = 0, fails = 0;
    int m_denials;
    bit m_forced;
    logic m_en;
    logic [REG_ADDR_WIDTH-1:0] m_addr;
    logic [DATA_WIDTH-1:0] m_data;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_denials = 0;
        m_forced  = 0;
        m_en      = 0;
        m_addr    = '0;
        m_data    = '0;
    endtask

    // One cycle: drive at negedge, check readies, advance model, check registered write after posedge.
    task automatic step(input logic wv, input logic [4:0] wa, input logic [31:0] wd,
                        input logic lv, input logic [4:0] la, input logic [31:0] ld,
                        output bit wg, output bit lg);
        wb_valid_i = wv; wb_addr_i = wa; wb_data_i = wd;
        ll_valid_i = lv; ll_addr_i = la; ll_data_i = ld;
        #1;
        wg = wv && !m_forced;
        lg = lv && !wg && (m_forced || !wv);
        chk("wb_ready", wb_ready_o, wg);
        chk("ll_ready", ll_ready_o, lg);
        chk("ll_forced", ll_forced_o, m_forced);
        chk("starve_cnt", dut.starve_cnt, m_denials);
        if (m_forced) begin
            m_forced = 0;
            m_denials = 0;
        end else if (lv && !lg) begin
            m_denials++;
            if (m_denials == LIM) begin
                m_forced = 1;
                m_denials = 0;
            end
        end else m_denials = 0;
        if (wg || lg) begin
            m_addr = wg ? wa : la;
            m_data = wg ? wd : ld;
            m_en   = m_addr != 0;
        end else m_en = 0;
        @(posedge clk);
        #1;
        chk("rd_write_en", rd_write_en_o, m_en);
        chk("rd_addr", rd_addr_o, m_addr);
        chk("rd_data", rd_data_o, m_data);
        @(negedge clk);
    endtask

    initial begin
        bit wg, lg, wp, lp;
        logic [4:0] wa, la;
        logic [31:0] wd, ld;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_en", rd_write_en_o, 1'b0);
        rst_n = 1'b1;
        // WB alone to x5
        step(1, 5, 32'hDEADBEEF, 0, 0, 0, wg, lg);
        chk("wb_only_addr", rd_addr_o, 5);
        chk("wb_only_data", rd_data_o, 32'hDEADBEEF);
        step(0, 0, 0, 0, 0, 0, wg, lg);
        // LL alone to x9, no forced entry
        step(0, 0, 0, 1, 9, 32'hA5A5A5A5, wg, lg);
        chk("ll_only_data", rd_data_o, 32'hA5A5A5A5);
        step(0, 0, 0, 0, 0, 0, wg, lg);
        // x0 destinations
        step(1, 0, 32'hFFFFFFFF, 0, 0, 0, wg, lg);
        step(0, 0, 0, 1, 0, 32'h77, wg, lg);
        // same rd from both: WB first, LL next
        step(1, 3, 32'h11, 1, 3, 32'h22, wg, lg);
        chk("same_rd_wb", rd_data_o, 32'h11);
        step(0, 0, 0, 1, 3, 32'h22, wg, lg);
        chk("same_rd_ll", rd_data_o, 32'h22);
        // contention: WB every cycle, LL x7 held until forced grant
        for (int i = 0; i < 4; i++) step(1, 5'(10 + i), 32'(i), 1, 7, 32'h1234, wg, lg);
        chk("forced_entry", ll_forced_o, 1'b1);
        step(1, 20, 32'hBB, 1, 7, 32'h1234, wg, lg);
        chk("forced_ll_addr", rd_addr_o, 7);
        chk("forced_ll_data", rd_data_o, 32'h1234);
        step(1, 20, 32'hBB, 0, 0, 0, wg, lg);
        chk("wb_resumes", rd_data_o, 32'hBB);
        // reset mid-stream with both valid
        wb_valid_i = 1; ll_valid_i = 1;
        step(1, 4, 32'h44, 1, 6, 32'h66, wg, lg);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_en", rd_write_en_o, 1'b0);
        chk("rst_addr", rd_addr_o, 0);
        chk("rst_data", rd_data_o, 0);
        chk("rst_wb_ready", wb_ready_o, 1'b0);
        chk("rst_ll_ready", ll_ready_o, 1'b0);
        chk("rst_forced", ll_forced_o, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        // random traffic with hold-until-accepted requesters
        wp = 0; lp = 0; wa = 0; la = 0; wd = 0; ld = 0;
        for (int i = 0; i < 400; i++) begin
            if (!wp && $urandom_range(3) != 0) begin
                wp = 1; wa = 5'($urandom_range(31)); wd = $urandom;
            end
            if (!lp && $urandom_range(1) != 0) begin
                lp = 1; la = 5'($urandom_range(31)); ld = $urandom;
            end
            step(wp, wa, wd, lp, la, ld, wg, lg);
            if (wg) wp = 0;
            if (lg) lp = 0;
        end
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
